// File: rtl/prga_tzc_reg.sv
// -----------------------------------------------------------------------------
// prga_tzc_reg
//  Registered trailing-zero counter. Reports the index of the least-significant
//  set bit of data_i and flags an all-zero word. The combinational core is a
//  log-depth pairwise reduction tree. Results are registered and appear exactly
//  one cycle after a word is accepted. There is no backpressure, so a new word
//  can be accepted every cycle.
//
//  Parameters
//   COUNTER_WIDTH : width of cnt_o. Must satisfy 2**COUNTER_WIDTH >= DATA_WIDTH.
//   DATA_WIDTH    : width of data_i. Any value >= 1.
//
//  Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   val_i      in   data_i is valid this cycle
//   data_i     in   word to scan
//   val_o      out  cnt_o / all_zero_o hold a fresh result
//   cnt_o      out  number of trailing zeros (index of lowest 1)
//   all_zero_o out  sampled word was all zeros; cnt_o is then 0
// -----------------------------------------------------------------------------
module prga_tzc_reg #(
    parameter int COUNTER_WIDTH = 4,
    parameter int DATA_WIDTH    = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     val_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     val_o,
    output logic [COUNTER_WIDTH-1:0] cnt_o,
    output logic                     all_zero_o
);

    localparam int PAD_WIDTH = 1 << COUNTER_WIDTH;

    // Pairwise reduction tree. Each node carries {zero flag, partial count}.
    // Nodes are reduced in place: node n of level l is built from nodes 2n and
    // 2n+1 of level l-1, which always sit at or above index n, so nothing is
    // overwritten before it is read. The lower half wins when it holds a 1;
    // otherwise the upper half's count is taken with the new level bit set.
    function automatic logic [COUNTER_WIDTH:0] tzc_tree(input logic [PAD_WIDTH-1:0] word);
        logic [PAD_WIDTH-1:0]     zf;
        logic [COUNTER_WIDTH-1:0] cn [PAD_WIDTH];
        logic [COUNTER_WIDTH-1:0] hi;
        for (int n = 0; n < PAD_WIDTH; n++) begin
            zf[n] = ~word[n];
            cn[n] = '0;
        end
        for (int l = 1; l <= COUNTER_WIDTH; l++) begin
            for (int n = 0; n < (PAD_WIDTH >> l); n++) begin
                hi = cn[2*n+1] | COUNTER_WIDTH'(32'd1 << (l - 1));
                if (zf[2*n] == 1'b0) begin
                    cn[n] = cn[2*n];
                end else begin
                    cn[n] = hi;
                end
                zf[n] = zf[2*n] & zf[2*n+1];
            end
        end
        return {zf[0], cn[0]};
    endfunction

    logic [PAD_WIDTH-1:0]     pad_s;
    logic [COUNTER_WIDTH:0]   tree_s;
    logic                     all_zero_s;
    logic [COUNTER_WIDTH-1:0] cnt_s;

    logic                     val_r;
    logic [COUNTER_WIDTH-1:0] cnt_r;
    logic                     all_zero_r;

    // Pad with ones above DATA_WIDTH so the padding is only ever selected for
    // an all-zero word, which is masked below; padding never injects X.
    always_comb begin
        pad_s                 = '1;
        pad_s[DATA_WIDTH-1:0] = data_i;
        tree_s                = tzc_tree(pad_s);
        all_zero_s            = ~|data_i;
        if (all_zero_s) begin
            cnt_s = '0;
        end else begin
            cnt_s = tree_s[COUNTER_WIDTH-1:0];
        end
    end

    // Output register: capture on valid, otherwise drop val and hold the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_r      <= 1'b0;
            cnt_r      <= '0;
            all_zero_r <= 1'b1;
        end else if (val_i) begin
            val_r      <= 1'b1;
            cnt_r      <= cnt_s;
            all_zero_r <= all_zero_s;
        end else begin
            val_r      <= 1'b0;
        end
    end

    assign val_o      = val_r;
    assign cnt_o      = cnt_r;
    assign all_zero_o = all_zero_r;

endmodule

// File: tb/tb_prga_tzc_reg.sv
// Scoreboard bench for prga_tzc_reg (COUNTER_WIDTH=4, DATA_WIDTH=13).
// The driver pushes the hand-computed {cnt, all_zero} for each valid word; a
// monitor pops and compares whenever val_o is high on a falling edge.
module tb_prga_tzc_reg;

    localparam int CW = 4;
    localparam int DW = 13;

    logic          clk;
    logic          rst_n;
    logic          val_i;
    logic [DW-1:0] data_i;
    logic          val_o;
    logic [CW-1:0] cnt_o;
    logic          all_zero_o;

    logic [CW:0]   exp_q[$];
    int            n_cmp;
    int            n_bad;

    prga_tzc_reg #(.COUNTER_WIDTH(CW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .val_i      (val_i),
        .data_i     (data_i),
        .val_o      (val_o),
        .cnt_o      (cnt_o),
        .all_zero_o (all_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one valid word (called just after a rising edge) and record its
    // expected result; returns just after the capturing edge.
    task automatic send(input logic [DW-1:0] d, input int c, input logic az);
        val_i  = 1'b1;
        data_i = d;
        exp_q.push_back({CW'(c), az});
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented result against the scoreboard.
    always @(negedge clk) begin
        if (val_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_val_o", 1, 0);
            end else begin
                logic [CW:0] e;
                e = exp_q.pop_front();
                check("cnt", int'(cnt_o), int'(e[CW:1]));
                check("all_zero", int'(all_zero_o), int'(e[0]));
            end
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        int            c;
        logic          az;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        val_i  = 1'b0;
        data_i = '0;

        vecs.push_back('{13'b1_1111_1111_1111, 0,  1'b0});
        vecs.push_back('{13'b0_0000_0000_0000, 0,  1'b1});
        vecs.push_back('{13'b1_1010_0101_0000, 4,  1'b0});
        vecs.push_back('{13'b0_1100_0100_0000, 6,  1'b0});
        vecs.push_back('{13'b1_1100_0011_0010, 1,  1'b0});
        vecs.push_back('{13'b1_1000_1010_0000, 5,  1'b0});
        vecs.push_back('{13'b1_0000_0000_0000, 12, 1'b0});
        vecs.push_back('{13'b0_0000_0000_0001, 0,  1'b0});
        vecs.push_back('{13'b0_1000_0000_0000, 11, 1'b0});
        vecs.push_back('{13'b0_0001_0000_0000, 8,  1'b0});

        // Reset state while rst_n is held low.
        #12;
        check("rst_val_o", int'(val_o), 0);
        check("rst_cnt_o", int'(cnt_o), 0);
        check("rst_all_zero_o", int'(all_zero_o), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back stream, one word per cycle.
        foreach (vecs[i]) send(vecs[i].d, vecs[i].c, vecs[i].az);

        // Idle with toggling data: outputs hold the last result (cnt 8, az 0).
        val_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_i = (k % 2 == 0) ? 13'h1FFF : 13'h0000;
            @(posedge clk);
            #1;
            check("idle_val_o", int'(val_o), 0);
            check("idle_cnt_o", int'(cnt_o), 8);
            check("idle_all_zero_o", int'(all_zero_o), 0);
        end

        // Word A is captured, word B is in flight when reset hits.
        send(13'h0010, 4, 1'b0);
        val_i  = 1'b1;
        data_i = 13'h1000;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_val_o", int'(val_o), 0);
        check("async_rst_cnt_o", int'(cnt_o), 0);
        check("async_rst_all_zero_o", int'(all_zero_o), 1);
        @(posedge clk);
        #1;
        check("held_rst_val_o", int'(val_o), 0);
        val_i = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_val_o", int'(val_o), 0);
            check("post_rst_cnt_o", int'(cnt_o), 0);
        end

        send(13'h0400, 10, 1'b0);
        val_i = 1'b0;

        // Drain: every expected result must have been presented.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        check("drain_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
